// File: rtl/spi_sender_buffer_pkg.sv
// Shared definitions for the SPI transmit buffer: FSM encoding, default frame width
// and the sender flag layout consumed by the status combiner.
package spi_sender_buffer_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Bit positions of the sender flags inside the status word.
    localparam int unsigned FLAG_EMPTY_BIT    = 0;
    localparam int unsigned FLAG_FULL_BIT     = 1;
    localparam int unsigned FLAG_BUF_FULL_BIT = 2;
    localparam int unsigned FLAG_W            = 3;

    typedef struct packed {
        logic buffer_full;
        logic full;
        logic empty;
    } sender_flags_t;

endpackage

// File: rtl/spi_sender_buffer_if.sv
// Host push port plus SPI pins and sender flags of the transmit buffer.
interface spi_sender_buffer_if #(
    parameter int unsigned DATA_W = spi_sender_buffer_pkg::DATA_W_DEF
);
    logic              SENDER_WRITE;
    logic [DATA_W-1:0] DATA_IN;
    logic              SCK;
    logic              MOSI;
    logic              CS_N;
    logic              SENDER_EMPTY_STATE;
    logic              SENDER_FULL_STATE;
    logic              SENDER_BUFFER_FULL_STATE;
    logic              WRITE_DROPPED;

    modport master (
        output SENDER_WRITE, DATA_IN,
        input  SCK, MOSI, CS_N, SENDER_EMPTY_STATE, SENDER_FULL_STATE,
               SENDER_BUFFER_FULL_STATE, WRITE_DROPPED
    );

    modport slave (
        input  SENDER_WRITE, DATA_IN,
        output SCK, MOSI, CS_N, SENDER_EMPTY_STATE, SENDER_FULL_STATE,
               SENDER_BUFFER_FULL_STATE, WRITE_DROPPED
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock byte FIFO; a push into a full FIFO is taken only when a pop
// happens in the same cycle.
module spi_sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        rdata_c,
    output logic [$clog2(DEPTH):0]   count_nxt_c,
    output logic                     full_c,
    output logic                     empty_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q < CNT_W'(DEPTH)) || do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: flushing is done by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

    assign rdata_c     = mem_q[rptr_q];
    assign count_nxt_c = count_d;
    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign empty_c     = (count_q == '0);

endmodule

// File: rtl/spi_sender_buffer.sv
// SPI master transmit side: byte FIFO feeding a mode-0, MSB-first shift engine
// with back-to-back frames and registered sender flags.
module spi_sender_buffer
    import spi_sender_buffer_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic              S_CLK,
    input  logic              CLR_N,
    spi_sender_buffer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              sck_q, sck_d;
    logic              cs_n_q, cs_n_d;
    logic              drop_q, drop_d;
    sender_flags_t     flags_q, flags_d;

    logic              pop;
    logic              div_wrap;
    logic [DATA_W-1:0] fifo_rdata_c;
    logic [CNT_W-1:0]  fifo_count_nxt_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;

    spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i       (S_CLK),
        .rst_ni      (CLR_N),
        .push_i      (bus.SENDER_WRITE),
        .data_i      (bus.DATA_IN),
        .pop_i       (pop),
        .rdata_c     (fifo_rdata_c),
        .count_nxt_c (fifo_count_nxt_c),
        .full_c      (fifo_full_c),
        .empty_c     (fifo_empty_c)
    );

    // Next-state, divider and shift logic; MOSI is the shift register MSB.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        sck_d    = sck_q;
        cs_n_d   = cs_n_q;
        pop      = 1'b0;
        div_wrap = (div_q == DIV_W'(CLK_DIV - 1));

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pop     = 1'b1;
                sh_d    = fifo_rdata_c;
                cs_n_d  = 1'b0;
                sck_d   = 1'b0;
                bit_d   = '0;
                div_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                div_d = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) begin
                    sck_d = ~sck_q;
                    // Data only moves on the falling SCK edge.
                    if (sck_q) begin
                        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                        bit_d = bit_q + BIT_W'(1);
                        if (bit_q == BIT_W'(DATA_W - 1)) begin
                            if (!fifo_empty_c) begin
                                state_d = ST_LOAD;
                            end else begin
                                state_d = ST_GAP;
                                cs_n_d  = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_GAP: begin
                cs_n_d = 1'b1;
                sck_d  = 1'b0;
                div_d  = div_wrap ? '0 : div_q + DIV_W'(1);
                if (div_wrap) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        drop_d              = bus.SENDER_WRITE && fifo_full_c && !pop;
        flags_d.empty       = (fifo_count_nxt_c == '0) && (state_d == ST_IDLE);
        flags_d.full        = (fifo_count_nxt_c == CNT_W'(DEPTH));
        flags_d.buffer_full = (state_d != ST_IDLE);
    end

    always_ff @(posedge S_CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            drop_q  <= 1'b0;
            flags_q <= '{buffer_full: 1'b0, full: 1'b0, empty: 1'b1};
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            drop_q  <= drop_d;
            flags_q <= flags_d;
        end
    end

    assign bus.SCK                      = sck_q;
    assign bus.MOSI                     = sh_q[DATA_W-1];
    assign bus.CS_N                     = cs_n_q;
    assign bus.SENDER_EMPTY_STATE       = flags_q.empty;
    assign bus.SENDER_FULL_STATE        = flags_q.full;
    assign bus.SENDER_BUFFER_FULL_STATE = flags_q.buffer_full;
    assign bus.WRITE_DROPPED            = drop_q;

endmodule
